os_assembler: RTL and testbench

- Upstream feeder of the RX ordered-set checker.
- Takes the per-lane decoded symbol stream (one 8-bit symbol plus K flag per accepted cycle), aligns on COM, and collects 16 symbols into one 128-bit TS1/TS2 ordered set.
- Validates the framing of each set, then presents it to the checker with a single-cycle valid strobe.
- Also reports framing errors and an ordered-set lock indication to the LTSSM.

---
 rtl/os_assembler.sv | 129 ++++++++++++
 tb/tb_os_assembler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_assembler.sv
// Aligns the decoded RX symbol stream on COM and assembles 16-symbol TS1/TS2 ordered sets,
// flagging framing errors and tracking ordered-set lock. Optional OS_ASM_ERRCNT_EN adds err_count.
module os_assembler #(
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  PAD_SYM    = 8'hF7,
  parameter logic [7:0]  TS1_ID     = 8'h4A,
  parameter logic [7:0]  TS2_ID     = 8'h45,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_datak,
  input  logic         rx_valid,
  output logic [127:0] orderedset,
  output logic         os_valid,
  output logic         os_error,
  output logic         os_lock
`ifdef OS_ASM_ERRCNT_EN
  ,
  output logic [7:0]   err_count
`endif
);

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [15:0][7:0] sym_q;
  logic [127:0]     orderedset_q;
  logic             os_valid_q;
  logic             os_error_q;
  logic             os_lock_q;
  logic [3:0]       good_cnt_q;

  logic             is_com;
  logic             sym_ok;
  logic [15:0][7:0] full_set_d;
  logic [3:0]       good_cnt_d;

  always_comb begin
    is_com = rx_datak && (rx_data == COM_SYM);
    sym_ok = 1'b0;
    if (idx_q == 4'd1 || idx_q == 4'd2)
      sym_ok = !rx_datak || (rx_data == PAD_SYM);
    else if (idx_q >= 4'd3 && idx_q <= 4'd5)
      sym_ok = !rx_datak;
    else if (idx_q == 4'd6)
      sym_ok = !rx_datak && (rx_data == TS1_ID || rx_data == TS2_ID);
    else if (idx_q >= 4'd7)
      sym_ok = !rx_datak && (rx_data == sym_q[6]);

    full_set_d     = sym_q;
    full_set_d[15] = rx_data;
    good_cnt_d     = (good_cnt_q >= LOCK_MAX) ? LOCK_MAX : good_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HUNT;
      idx_q        <= 4'd0;
      sym_q        <= '0;
      orderedset_q <= '0;
      os_valid_q   <= 1'b0;
      os_error_q   <= 1'b0;
      os_lock_q    <= 1'b0;
      good_cnt_q   <= 4'd0;
`ifdef OS_ASM_ERRCNT_EN
      err_count    <= 8'd0;
`endif
    end else begin
      os_valid_q <= 1'b0;
      os_error_q <= 1'b0;
      if (rx_valid) begin
        case (state_q)
          HUNT: begin
            if (is_com) begin
              sym_q[0] <= rx_data;
              idx_q    <= 4'd1;
              state_q  <= COLLECT;
            end
          end
          COLLECT: begin
            if (sym_ok) begin
              sym_q[idx_q] <= rx_data;
              if (idx_q == 4'd15) begin
                orderedset_q <= full_set_d;
                os_valid_q   <= 1'b1;
                good_cnt_q   <= good_cnt_d;
                os_lock_q    <= (good_cnt_d == LOCK_MAX);
                idx_q        <= 4'd0;
                state_q      <= HUNT;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end else begin
              os_error_q <= 1'b1;
              good_cnt_q <= 4'd0;
              os_lock_q  <= 1'b0;
`ifdef OS_ASM_ERRCNT_EN
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
              // A COM that breaks the current set is taken as the start of the next one
              if (is_com) begin
                sym_q[0] <= rx_data;
                idx_q    <= 4'd1;
              end else begin
                idx_q   <= 4'd0;
                state_q <= HUNT;
              end
            end
          end
          default: begin
            idx_q   <= 4'd0;
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  assign orderedset = orderedset_q;
  assign os_valid   = os_valid_q;
  assign os_error   = os_error_q;
  assign os_lock    = os_lock_q;

endmodule

// File: tb/tb_os_assembler.sv
// Scoreboarded bench for os_assembler: good sets are queued as driven and popped on os_valid.
module tb_os_assembler;

  typedef logic [15:0][7:0] set_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_datak = 1'b0;
  logic         rx_valid = 1'b0;
  logic [127:0] orderedset;
  logic         os_valid;
  logic         os_error;
  logic         os_lock;
`ifdef OS_ASM_ERRCNT_EN
  logic [7:0]   err_count;
`endif

  os_assembler dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_datak   (rx_datak),
    .rx_valid   (rx_valid),
    .orderedset (orderedset),
    .os_valid   (os_valid),
    .os_error   (os_error),
    .os_lock    (os_lock)
`ifdef OS_ASM_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   drive_cyc = 0;
  int   start_cyc = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  set_t exp_q[$];
  set_t mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every os_valid must match the oldest queued set
  always @(negedge clk) begin
    if (reset && os_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: got set %h, expected no strobe", orderedset);
      end else begin
        mon_exp = exp_q.pop_front();
        if (orderedset !== mon_exp) begin
          errors++;
          $display("FAIL sb_set: got %h, expected %h", orderedset, mon_exp);
        end else begin
          $display("os_valid set %h ok (cycle %0d)", orderedset, cyc);
        end
      end
    end
    if (reset && (os_valid || os_error)) begin
      checks++;
      if (os_valid && os_error) begin
        errors++;
        $display("FAIL valid_error_exclusive: got both strobes, expected at most one");
      end
    end
    if (reset && os_error) err_seen++;
  end

  function automatic set_t make_ts(input logic [7:0] link, input logic [7:0] lane,
                                   input logic [7:0] s3, input logic [7:0] s4,
                                   input logic [7:0] s5, input logic [7:0] id);
    set_t s;
    s[0] = 8'hBC; s[1] = link; s[2] = lane; s[3] = s3; s[4] = s4; s[5] = s5;
    for (int i = 6; i < 16; i++) s[i] = id;
    return s;
  endfunction

  task automatic send_sym(input logic [7:0] d, input logic k);
    rx_data = d; rx_datak = k; rx_valid = 1'b1;
    drive_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_range(input set_t s, input int lo, input int hi, input bit gap);
    logic k;
    for (int i = lo; i <= hi; i++) begin
      k = (i == 0) || ((i == 1 || i == 2) && s[i] == 8'hF7);
      send_sym(s[i], k);
      if (i == lo) start_cyc = drive_cyc;
      if (gap && i < hi) idle(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (orderedset !== 128'h0) begin errors++; $display("FAIL rst_orderedset: got %h, expected 0", orderedset); end
    checks++; if (os_valid !== 1'b0) begin errors++; $display("FAIL rst_os_valid: got %b, expected 0", os_valid); end
    checks++; if (os_error !== 1'b0) begin errors++; $display("FAIL rst_os_error: got %b, expected 0", os_error); end
    checks++; if (os_lock !== 1'b0) begin errors++; $display("FAIL rst_os_lock: got %b, expected 0", os_lock); end
    reset = 1'b1;
    idle(1);
    $display("test_reset done");
  endtask

  task automatic test_ts1_good();
    set_t s;
    s = make_ts(8'hF7, 8'hF7, 8'h00, 8'h01, 8'h02, 8'h4A);
    exp_q.push_back(s);
    send_range(s, 0, 15, 1'b0);
    checks++; if (os_valid !== 1'b1) begin errors++; $display("FAIL ts1_valid: got %b, expected 1", os_valid); end
    checks++; if (orderedset[7:0] !== 8'hBC) begin errors++; $display("FAIL ts1_sym0: got %h, expected bc", orderedset[7:0]); end
    checks++; if (orderedset[15:8] !== 8'hF7) begin errors++; $display("FAIL ts1_sym1: got %h, expected f7", orderedset[15:8]); end
    checks++; if (orderedset[87:80] !== 8'h4A) begin errors++; $display("FAIL ts1_sym10: got %h, expected 4a", orderedset[87:80]); end
    checks++; if (orderedset[127:120] !== 8'h4A) begin errors++; $display("FAIL ts1_sym15: got %h, expected 4a", orderedset[127:120]); end
    checks++; if (os_lock !== 1'b0) begin errors++; $display("FAIL ts1_lock: got %b, expected 0", os_lock); end
    idle(1);
    checks++; if (os_valid !== 1'b0) begin errors++; $display("FAIL ts1_strobe_width: got %b, expected 0", os_valid); end
    $display("test_ts1_good done");
  endtask

  task automatic test_back_to_back();
    set_t s;
    int   v1, v2;
    reset = 1'b0; #2; reset = 1'b1; idle(1);
    s = make_ts(8'h05, 8'h03, 8'h10, 8'h02, 8'h00, 8'h45);
    exp_q.push_back(s);
    exp_q.push_back(s);
    send_range(s, 0, 15, 1'b0);
    v1 = cyc;
    checks++; if (os_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b, expected 1", os_valid); end
    checks++; if (os_lock !== 1'b0) begin errors++; $display("FAIL b2b_lock1: got %b, expected 0", os_lock); end
    send_range(s, 0, 15, 1'b0);
    v2 = cyc;
    checks++; if (os_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b, expected 1", os_valid); end
    checks++; if (os_lock !== 1'b1) begin errors++; $display("FAIL b2b_lock2: got %b, expected 1", os_lock); end
    checks++; if (v2 - v1 != 16) begin errors++; $display("FAIL b2b_spacing: got %0d cycles, expected 16", v2 - v1); end
    checks++; if (orderedset[23:16] !== 8'h03) begin errors++; $display("FAIL b2b_lane: got %h, expected 03", orderedset[23:16]); end
    idle(1);
    $display("test_back_to_back done");
  endtask

  task automatic test_gapped();
    set_t s;
    s = make_ts(8'hF7, 8'hF7, 8'h00, 8'h01, 8'h02, 8'h4A);
    exp_q.push_back(s);
    send_range(s, 0, 15, 1'b1);
    checks++; if (os_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b, expected 1", os_valid); end
    checks++; if (cyc - start_cyc != 31) begin errors++; $display("FAIL gap_latency: got %0d cycles, expected 31", cyc - start_cyc); end
    checks++; if (orderedset !== s) begin errors++; $display("FAIL gap_set: got %h, expected %h", orderedset, s); end
    idle(1);
    $display("test_gapped done");
  endtask

  task automatic test_bad_id();
    set_t         s, bad;
    logic [127:0] prev;
    s = make_ts(8'hF7, 8'hF7, 8'h00, 8'h01, 8'h02, 8'h4A);
    bad = s;
    bad[9] = 8'h45;
    prev = orderedset;
    checks++; if (os_lock !== 1'b1) begin errors++; $display("FAIL bad_lock_before: got %b, expected 1", os_lock); end
    send_range(bad, 0, 9, 1'b0);
    err_exp++;
    checks++; if (os_error !== 1'b1) begin errors++; $display("FAIL bad_error: got %b, expected 1", os_error); end
    checks++; if (os_valid !== 1'b0) begin errors++; $display("FAIL bad_valid: got %b, expected 0", os_valid); end
    checks++; if (orderedset !== prev) begin errors++; $display("FAIL bad_hold: got %h, expected %h", orderedset, prev); end
    checks++; if (os_lock !== 1'b0) begin errors++; $display("FAIL bad_lock: got %b, expected 0", os_lock); end
    send_range(bad, 10, 15, 1'b0);
    idle(2);
    exp_q.push_back(s);
    send_range(s, 0, 15, 1'b0);
    checks++; if (os_valid !== 1'b1) begin errors++; $display("FAIL bad_recover: got %b, expected 1", os_valid); end
    idle(1);
    $display("test_bad_id done");
  endtask

  task automatic test_com_resync();
    set_t s;
    int   c_com;
    s = make_ts(8'hF7, 8'hF7, 8'h00, 8'h01, 8'h02, 8'h4A);
    send_range(s, 0, 7, 1'b0);
    send_sym(8'hBC, 1'b1);
    c_com = drive_cyc;
    err_exp++;
    checks++; if (os_error !== 1'b1) begin errors++; $display("FAIL resync_error: got %b, expected 1", os_error); end
    checks++; if (os_valid !== 1'b0) begin errors++; $display("FAIL resync_valid: got %b, expected 0", os_valid); end
    exp_q.push_back(s);
    send_range(s, 1, 15, 1'b0);
    checks++; if (os_valid !== 1'b1) begin errors++; $display("FAIL resync_done: got %b, expected 1", os_valid); end
    checks++; if (cyc - c_com != 16) begin errors++; $display("FAIL resync_latency: got %0d cycles, expected 16", cyc - c_com); end
    idle(1);
    $display("test_com_resync done");
  endtask

`ifdef OS_ASM_ERRCNT_EN
  task automatic test_err_count();
    for (int n = 0; n < 300; n++) begin
      send_sym(8'hBC, 1'b1);
      send_sym(8'h00, 1'b0);
      send_sym(8'h1C, 1'b1);
      err_exp++;
      checks++; if (os_error !== 1'b1) begin errors++; $display("FAIL errcnt_strobe: set %0d got %b, expected 1", n, os_error); end
    end
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL errcnt_sat: got %h, expected ff", err_count); end
    idle(3);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL errcnt_hold: got %h, expected ff", err_count); end
    $display("test_err_count done");
  endtask
`endif

  task automatic test_reset_mid_set();
    set_t s;
    s = make_ts(8'h05, 8'h03, 8'h10, 8'h02, 8'h00, 8'h4A);
    exp_q.push_back(s);
    exp_q.push_back(s);
    send_range(s, 0, 15, 1'b0);
    send_range(s, 0, 15, 1'b0);
    checks++; if (os_lock !== 1'b1) begin errors++; $display("FAIL midrst_lock_before: got %b, expected 1", os_lock); end
    send_range(s, 0, 7, 1'b0);
    reset = 1'b0; #2;
    checks++; if (orderedset !== 128'h0) begin errors++; $display("FAIL midrst_set: got %h, expected 0", orderedset); end
    checks++; if (os_lock !== 1'b0) begin errors++; $display("FAIL midrst_lock: got %b, expected 0", os_lock); end
    checks++; if (os_error !== 1'b0) begin errors++; $display("FAIL midrst_error: got %b, expected 0", os_error); end
`ifdef OS_ASM_ERRCNT_EN
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL midrst_errcnt: got %h, expected 00", err_count); end
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    send_range(s, 8, 15, 1'b0);
    idle(2);
    checks++; if (orderedset !== 128'h0) begin errors++; $display("FAIL midrst_partial: got %h, expected 0", orderedset); end
    $display("test_reset_mid_set done");
  endtask

  initial begin
    test_reset();
    test_ts1_good();
    test_back_to_back();
    test_gapped();
    test_bad_id();
    test_com_resync();
`ifdef OS_ASM_ERRCNT_EN
    test_err_count();
`endif
    test_reset_mid_set();
    idle(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d sets pending, expected 0", exp_q.size()); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL error_strobes: got %0d, expected %0d", err_seen, err_exp); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
